// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC readout block.
//   tdc_state_t       : readout FSM state encoding
//   DELAY_DEF         : default number of delay-line taps
//   CLEAR_CYCLES_DEF  : default clocks with start low before launch
//   SETTLE_CYCLES_DEF : default clocks between freeze and the tap scan
//   max_int()         : helper used for sizing counters
package tdc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SCAN   = 3'd4,
        ST_DONE   = 3'd5
    } tdc_state_t;

    localparam int DELAY_DEF         = 100;
    localparam int CLEAR_CYCLES_DEF  = 50;
    localparam int SETTLE_CYCLES_DEF = 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tdc_readout_if.sv
// Bundle between the TDC readout controller and its user / delay line.
//   go, freeze_delay, thermo           : request side (driven by master)
//   start, freeze, busy,
//   code, code_valid, code_err         : controller side (driven by slave)
// Modports: master = requester / delay line, slave = tdc_readout.
interface tdc_readout_if
    import tdc_pkg::*;
#(
    parameter int DELAY = DELAY_DEF
) ();

    logic             go;
    logic [7:0]       freeze_delay;
    logic [DELAY-1:0] thermo;
    logic             start;
    logic             freeze;
    logic             busy;
    logic [7:0]       code;
    logic             code_valid;
    logic             code_err;

    modport master (
        output go, freeze_delay, thermo,
        input  start, freeze, busy, code, code_valid, code_err
    );

    modport slave (
        input  go, freeze_delay, thermo,
        output start, freeze, busy, code, code_valid, code_err
    );

endinterface

// File: rtl/tdc_readout.sv
// Delay-line TDC measurement controller.
// Sequence: IDLE -> CLEAR (start low) -> LAUNCH (start high, wait
// freeze_delay+1) -> SETTLE (freeze high) -> SCAN (find first 0 tap)
// -> DONE (one-clock code_valid) -> IDLE.
// Ports:
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : tdc_readout_if.slave (go/freeze_delay/thermo in,
//          start/freeze/busy/code/code_valid/code_err out)
// CLEAR_CYCLES and SETTLE_CYCLES are expected to be at least 1.
module tdc_readout
    import tdc_pkg::*;
#(
    parameter int DELAY         = DELAY_DEF,
    parameter int CLEAR_CYCLES  = CLEAR_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input logic          clk,
    input logic          rstn,
    tdc_readout_if.slave bus
);

    localparam int IDX_W = $clog2(DELAY + 1);
    // Counter must reach CLEAR/SETTLE lengths and freeze_delay (up to 255).
    localparam int CNT_W = max_int(max_int($clog2(CLEAR_CYCLES + 1),
                                           $clog2(SETTLE_CYCLES + 1)), 9);

    localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(DELAY - 1);

    tdc_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [7:0]       fd_reg;
    logic             start_reg;
    logic             freeze_reg;
    logic             busy_reg;
    logic [7:0]       code_reg;
    logic             code_valid_reg;
    logic             code_err_reg;

    // Tap mux: one-hot AND-OR over the frozen taps, selected by idx_reg.
    logic [DELAY-1:0] tap_hit;
    logic             tap_bit;

    for (genvar gi = 0; gi < DELAY; gi++) begin : g_tap
        assign tap_hit[gi] = (idx_reg == IDX_W'(gi)) && bus.thermo[gi];
    end
    assign tap_bit = |tap_hit;

    // Tap index saturated to the 8-bit code range.
    function automatic logic [7:0] sat_code(input logic [IDX_W-1:0] i);
        logic [31:0] ext;
        ext = 32'(i);
        return (ext > 32'd255) ? 8'hFF : ext[7:0];
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            fd_reg         <= '0;
            start_reg      <= 1'b0;
            freeze_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            code_reg       <= '0;
            code_valid_reg <= 1'b0;
            code_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // start/freeze are left as the previous run left them
                    // so the line stays frozen for readback.
                    if (bus.go) begin
                        state_reg  <= ST_CLEAR;
                        fd_reg     <= bus.freeze_delay;
                        start_reg  <= 1'b0;
                        freeze_reg <= 1'b0;
                        busy_reg   <= 1'b1;
                        cnt_reg    <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_reg == CLEAR_LAST) begin
                        state_reg <= ST_LAUNCH;
                        start_reg <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    if (cnt_reg == CNT_W'(fd_reg)) begin
                        state_reg  <= ST_SETTLE;
                        freeze_reg <= 1'b1;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_reg == SETTLE_LAST) begin
                        state_reg <= ST_SCAN;
                        idx_reg   <= '0;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (!tap_bit) begin
                        // Zero at tap 0 means the edge never entered the line.
                        code_reg       <= sat_code(idx_reg);
                        code_err_reg   <= (idx_reg == '0);
                        code_valid_reg <= 1'b1;
                        state_reg      <= ST_DONE;
                    end else if (idx_reg == IDX_LAST) begin
                        code_reg       <= 8'hFF;
                        code_err_reg   <= 1'b1;
                        code_valid_reg <= 1'b1;
                        state_reg      <= ST_DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    code_valid_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                    state_reg      <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start      = start_reg;
    assign bus.freeze     = freeze_reg;
    assign bus.busy       = busy_reg;
    assign bus.code       = code_reg;
    assign bus.code_valid = code_valid_reg;
    assign bus.code_err   = code_err_reg;

endmodule

// File: doc/tdc_readout.md
TDC_READOUT -- requirements
Module: tdc_readout

Interface
REQ-001 Parameter DELAY, default 100: number of delay-line taps on thermo.
REQ-002 Parameter CLEAR_CYCLES, default 50: clocks with start low before launch.
REQ-003 Parameter SETTLE_CYCLES, default 10: clocks after freeze before the scan begins.
REQ-004 Port clk  in  1: single clock; all logic on rising edge.
REQ-005 Port rstn  in  1: reset, asynchronous assert, active-low.
REQ-006 Port go  in  1: measurement request; sampled only in IDLE.
REQ-007 Port freeze_delay  in  8: clocks from start assertion to freeze assertion; sampled when go is accepted.
REQ-008 Port thermo  in  DELAY: frozen delay-line taps; tap 0 is nearest the launch point.
REQ-009 Port start  out  1: launch edge into the delay line.
REQ-010 Port freeze  out  1: freeze command to the delay line.
REQ-011 Port busy  out  1: high in every state except IDLE.
REQ-012 Port code  out  8: decoded tap count; held until the next result.
REQ-013 Port code_valid  out  1: one-clock pulse when code and code_err are updated.
REQ-014 Port code_err  out  1: qualifies code; high means no valid transition was found.

Function
REQ-015 The FSM SHALL have states IDLE, CLEAR, LAUNCH, SETTLE, SCAN, DONE.
REQ-016 IDLE: go=1 -> CLEAR, latch freeze_delay, drive start=0 and freeze=0 from the next clock.
REQ-017 CLEAR SHALL last exactly CLEAR_CYCLES clocks, then -> LAUNCH with start=1.
REQ-018 LAUNCH SHALL hold start=1 for freeze_delay+1 clocks, then assert freeze=1 and -> SETTLE; freeze_delay=0 gives freeze one clock after start.
REQ-019 SETTLE SHALL last SETTLE_CYCLES clocks, then -> SCAN with the tap index at 0.
REQ-020 SCAN SHALL test one tap per clock in ascending order and stop at the first index i where thermo[i]=0.
REQ-021 Scan outcome: zero found at i>0 -> code=min(i,255), code_err=0.
REQ-022 Scan outcome: thermo[0]=0 (line never launched) -> code=0, code_err=1.
REQ-023 Scan outcome: no zero found by index DELAY-1 -> code=255, code_err=1.
REQ-024 Scan latency SHALL be (stopping index + 1) clocks; at most DELAY clocks.
REQ-025 DONE SHALL last one clock, pulse code_valid=1, then -> IDLE.
REQ-026 start and freeze SHALL remain high after DONE and clear only in CLEAR of the next measurement, so the line stays frozen for readback.
REQ-027 go SHALL be ignored whenever busy=1; no queuing.
REQ-028 Any change on thermo outside SCAN SHALL have no effect.
REQ-029 Index and counter widths SHALL be at least ceil(log2(DELAY+1)) bits and SHALL not wrap within a measurement.

Reset
REQ-030 rstn=0 SHALL asynchronously force state IDLE, start=0, freeze=0, busy=0, code=0, code_valid=0, code_err=0, and all counters to 0.
REQ-031 Reset mid-measurement SHALL abort the measurement with no code_valid pulse; the first measurement after rstn rises requires a fresh go.

Structure
REQ-032 The FSM state encoding and the CLEAR/SETTLE defaults SHALL be defined in a shared package, tdc_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; the tap mux is inline.

Verification
REQ-034 The bench SHALL cover: go with freeze_delay=3 and thermo = 37 ones then zeros -> start rises 51 clocks after go, freeze rises 4 clocks after start, code=37, code_err=0, single code_valid pulse.
REQ-035 The bench SHALL cover: thermo all ones, DELAY=100 -> code=255, code_err=1.
REQ-036 The bench SHALL cover: thermo[0]=0 -> code=0, code_err=1 after a 1-clock scan.
REQ-037 The bench SHALL cover: freeze_delay=0 -> freeze rises exactly one clock after start; go pulses while busy produce no extra measurement.
REQ-038 The bench SHALL cover: rstn pulsed low during SCAN -> all outputs 0 immediately with no code_valid; a subsequent go completes normally.
REQ-039 The bench SHALL cover: two back-to-back measurements -> start and freeze stay high between them and drop at the second CLEAR.
